// File: rtl/access_sequencer_if.sv
// Bus bundle between the door-lock sequencer and its keypad/actuator side.
// The master drives the keypad inputs. The slave (the sequencer) drives the
// actuator and status outputs.
interface access_sequencer_if #(
    parameter int unsigned PW_W = 17
) ();
    logic [PW_W-1:0] in_password;
    logic [PW_W-1:0] change_password;
    logic            enter_btn;
    logic            rs_btn;
    logic            unlock;
    logic            alarm;
    logic            locked_out;
    logic            pw_changed;
    logic [2:0]      fail_count;

    modport master (
        output in_password, change_password, enter_btn, rs_btn,
        input  unlock, alarm, locked_out, pw_changed, fail_count
    );

    modport slave (
        input  in_password, change_password, enter_btn, rs_btn,
        output unlock, alarm, locked_out, pw_changed, fail_count
    );
endinterface

// File: rtl/access_sequencer.sv
// Smart-home door lock sequencer. It holds the stored password, runs the
// master-key change flow, counts failed attempts, times the lockout and
// auto-relocks the door. Button edges become single entry events, and every
// output is registered.
module access_sequencer #(
    parameter int unsigned     PW_W           = 17,
    parameter logic [PW_W-1:0] MASTER_KEY     = 17'd45675,
    parameter logic [PW_W-1:0] DEFAULT_PW     = 17'd12345,
    parameter int unsigned     MAX_FAILS      = 3,
    parameter int unsigned     LOCKOUT_CYCLES = 16,
    parameter int unsigned     UNLOCK_CYCLES  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    access_sequencer_if.slave bus
);
    // One shared down-counter serves both OPEN and LOCKOUT, so it is sized
    // for the longer of the two intervals.
    localparam int unsigned CNT_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ?
                                      LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [2:0]  MAX_F   = 3'(MAX_FAILS);

    typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCKOUT} state_t;

    state_t            state_q, state_d;
    logic [PW_W-1:0]   stored_pw_q, stored_pw_d;
    logic [PW_W-1:0]   cap_pw_q, cap_pw_d;
    logic [PW_W-1:0]   cap_chg_q, cap_chg_d;
    logic              cap_rs_q, cap_rs_d;
    logic [2:0]        fail_q, fail_d;
    logic              alarm_q, alarm_d;
    logic              unlock_q, unlock_d;
    logic              locked_q, locked_d;
    logic              pw_chg_q, pw_chg_d;
    logic              btn_prev_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        fail_inc;
    logic              entry_ev;

    // A rising edge of the enter button is one entry event, however long the button is held.
    assign entry_ev = bus.enter_btn & ~btn_prev_q;

    // Register all state. The reset acts at once, even in the middle of an operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stored_pw_q <= DEFAULT_PW;
            cap_pw_q    <= '0;
            cap_chg_q   <= '0;
            cap_rs_q    <= 1'b0;
            fail_q      <= 3'd0;
            alarm_q     <= 1'b0;
            unlock_q    <= 1'b0;
            locked_q    <= 1'b0;
            pw_chg_q    <= 1'b0;
            btn_prev_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            stored_pw_q <= stored_pw_d;
            cap_pw_q    <= cap_pw_d;
            cap_chg_q   <= cap_chg_d;
            cap_rs_q    <= cap_rs_d;
            fail_q      <= fail_d;
            alarm_q     <= alarm_d;
            unlock_q    <= unlock_d;
            locked_q    <= locked_d;
            pw_chg_q    <= pw_chg_d;
            btn_prev_q  <= bus.enter_btn;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state and next-output logic. Everything holds unless a state changes it.
    always_comb begin
        state_d     = state_q;
        stored_pw_d = stored_pw_q;
        cap_pw_d    = cap_pw_q;
        cap_chg_d   = cap_chg_q;
        cap_rs_d    = cap_rs_q;
        fail_d      = fail_q;
        alarm_d     = alarm_q;
        unlock_d    = unlock_q;
        locked_d    = locked_q;
        pw_chg_d    = 1'b0;
        cnt_d       = cnt_q;
        fail_inc    = (fail_q >= MAX_F) ? MAX_F : fail_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (entry_ev) begin
                    cap_pw_d  = bus.in_password;
                    cap_chg_d = bus.change_password;
                    cap_rs_d  = bus.rs_btn;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                if (cap_rs_q && cap_pw_q == MASTER_KEY) begin
                    stored_pw_d = cap_chg_q;
                    pw_chg_d    = 1'b1;
                    fail_d      = 3'd0;
                    alarm_d     = 1'b0;
                    state_d     = IDLE;
                end else if (!cap_rs_q && cap_pw_q == MASTER_KEY) begin
                    fail_d  = 3'd0;
                    alarm_d = 1'b0;
                    state_d = OPEN;
                end else if (!cap_rs_q && cap_pw_q == stored_pw_q) begin
                    // Only the master key clears a latched alarm.
                    fail_d  = 3'd0;
                    state_d = OPEN;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == MAX_F) begin
                        alarm_d  = 1'b1;
                        locked_d = 1'b1;
                        cnt_d    = CNT_W'(LOCKOUT_CYCLES - 1);
                        state_d  = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OPEN: begin
                // The first OPEN cycle raises unlock, which gives the two-edge unlock latency.
                if (entry_ev) begin
                    unlock_d = 1'b0;
                    state_d  = IDLE;
                end else if (!unlock_q) begin
                    unlock_d = 1'b1;
                    cnt_d    = CNT_W'(UNLOCK_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    unlock_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOCKOUT: begin
                // Entry events are dropped here. The fail count and alarm stay latched.
                if (cnt_q == '0) begin
                    locked_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.unlock     = unlock_q;
    assign bus.alarm      = alarm_q;
    assign bus.locked_out = locked_q;
    assign bus.pw_changed = pw_chg_q;
    assign bus.fail_count = fail_q;
endmodule
